// File: rtl/lbm_stream_if.sv
// lbm_stream_if
//   Bundles the control and RAM-side signals of the LBM streaming engine.
//   master : the engine (drives busy/done/cur_bank and the RAM read/write buses)
//   slave  : the solver top / RAM side (drives en, start and rd_data)
//   Per-direction buses are flat vectors; direction d occupies [d*AW +: AW]
//   or [d*DW +: DW], with d = 0..8 ordered C0, N, NE, E, SE, S, SW, W, NW.
interface lbm_stream_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic            en;
  logic            start;
  logic            busy;
  logic            done;
  logic            cur_bank;
  logic [9*AW-1:0] rd_addr;
  logic [9*DW-1:0] rd_data;
  logic [9*AW-1:0] wr_addr;
  logic [9*DW-1:0] wr_data;
  logic [8:0]      wr_en;

  modport master (
    input  en, start, rd_data,
    output busy, done, cur_bank, rd_addr, wr_addr, wr_data, wr_en
  );

  modport slave (
    output en, start, rd_data,
    input  busy, done, cur_bank, rd_addr, wr_addr, wr_data, wr_en
  );
endinterface

// File: rtl/lbm_stream_engine.sv
// lbm_stream_engine
//   Streaming step of the LBM solver. Sweeps the grid one destination cell
//   per cycle, pull-reads all nine directions from their upstream neighbours
//   in the source bank (cur_bank) and writes them to the same cell in the
//   destination bank (~cur_bank). Banks swap after each completed sweep.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : lbm_stream_if master (en/start in, busy/done/cur_bank out,
//                per-direction read/write RAM buses)
//   dbg_state  : current FSM state (IDLE=0, SWEEP=1, DRAIN=2, DONE=3)
// Control semantics: start is a request sampled only in IDLE; a sweep
//   then runs to completion. en is a per-cycle issue qualifier during SWEEP:
//   a read is issued in a cycle only when en=1 in that cycle; the write for
//   that read follows one cycle later regardless of en.
module lbm_stream_engine #(
  parameter int GRID_W     = 16,
  parameter int GRID_H     = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic         clk,
  input  logic         rst,
  lbm_stream_if.master bus,
  output logic [1:0]   dbg_state
);
  localparam int NCELL = GRID_W * GRID_H;
  localparam int XW    = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW    = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int AW    = ADDR_WIDTH;

  // Direction offsets, y increasing northward: C0 N NE E SE S SW W NW
  localparam int CX [9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
  localparam int CY [9] = '{0, 1, 1, 0, -1, -1, -1, 0, 1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            cur_bank_q, cur_bank_d;
  logic            pend_valid_q, pend_valid_d;
  logic [IW-1:0]   pend_idx_q, pend_idx_d;
  logic [9*AW-1:0] rd_addr_q, rd_addr_d;
  logic            issue;

  // Control FSM and sweep counters
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cur_bank_d   = cur_bank_q;
    pend_valid_d = 1'b0;
    pend_idx_d   = pend_idx_q;
    issue        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SWEEP;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_SWEEP: begin
        if (bus.en) begin
          issue        = 1'b1;
          pend_valid_d = 1'b1;
          pend_idx_d   = IW'(int'(y_q) * GRID_W + int'(x_q));
          if (x_q == XW'(GRID_W - 1)) begin
            x_d = '0;
            if (y_q == YW'(GRID_H - 1)) begin
              y_d     = '0;
              state_d = S_DRAIN;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        cur_bank_d = ~cur_bank_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Upstream (pull) read addresses with periodic wrap. When nothing is
  // issued the previous address is held so the RAM inputs stay quiet.
  always_comb begin
    int            sx;
    int            sy;
    logic [AW-1:0] a;
    sx        = 0;
    sy        = 0;
    a         = '0;
    rd_addr_d = rd_addr_q;
    if (issue) begin
      for (int d = 0; d < 9; d++) begin
        sx = int'(x_q) - CX[d];
        sy = int'(y_q) - CY[d];
        if (sx < 0) sx = sx + GRID_W;
        else if (sx >= GRID_W) sx = sx - GRID_W;
        if (sy < 0) sy = sy + GRID_H;
        else if (sy >= GRID_H) sy = sy - GRID_H;
        a          = '0;
        a[IW-1:0]  = IW'(sy * GRID_W + sx);
        a[AW-1]    = cur_bank_q;
        rd_addr_d[d*AW +: AW] = a;
      end
    end
  end

  // Write stage: the data returned for last cycle's reads goes straight to
  // the destination bank. Outputs are zeroed when no write is pending.
  always_comb begin
    logic [AW-1:0] wa;
    wa         = '0;
    wa[IW-1:0] = pend_idx_q;
    wa[AW-1]   = ~cur_bank_q;
    bus.wr_en   = {9{pend_valid_q}};
    bus.wr_addr = pend_valid_q ? {9{wa}} : '0;
    bus.wr_data = pend_valid_q ? bus.rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      cur_bank_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      rd_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cur_bank_q   <= cur_bank_d;
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  assign bus.rd_addr  = rd_addr_d;
  assign bus.busy     = (state_q == S_SWEEP) || (state_q == S_DRAIN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.cur_bank = cur_bank_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_lbm_stream_engine.sv
// tb_lbm_stream_engine
//   Bench for lbm_stream_engine on a 4x4 grid with nine behavioural RAMs
//   (synchronous read, write on wr_en). A reference copy of the RAM contents
//   is maintained by the bench alone and used to predict every write.
module tb_lbm_stream_engine;
  localparam int GW = 4;
  localparam int GH = 4;
  localparam int N  = GW * GH;
  localparam int DW = 16;
  localparam int AW = 9;
  localparam int MW = 9 * AW + 9 * DW;
  localparam int CXT [9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
  localparam int CYT [9] = '{0, 1, 1, 0, -1, -1, -1, 0, 1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] dbg_state;
  lbm_stream_if #(.AW(AW), .DW(DW)) bus ();

  lbm_stream_engine #(
    .GRID_W(GW), .GRID_H(GH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- RAM model ----------------
  logic [DW-1:0]   mem     [9][512];
  logic [DW-1:0]   ref_mem [9][512];
  logic [9*DW-1:0] rd_data_q;
  logic            clr_req = 1'b0;
  logic            ld_req  = 1'b0;
  logic [3:0]      ld_d    = '0;
  logic [AW-1:0]   ld_a    = '0;
  logic [DW-1:0]   ld_v    = '0;
  int              ref_bank;

  assign bus.rd_data = rd_data_q;

  always @(posedge clk) begin
    for (int d = 0; d < 9; d++) begin
      rd_data_q[d*DW +: DW] <= mem[d][bus.rd_addr[d*AW +: AW]];
      if (bus.wr_en[d]) mem[d][bus.wr_addr[d*AW +: AW]] <= bus.wr_data[d*DW +: DW];
    end
    if (clr_req)
      for (int d = 0; d < 9; d++)
        for (int a = 0; a < 512; a++) mem[d][a] <= '0;
    if (ld_req) mem[ld_d][ld_a] <= ld_v;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [MW-1:0] exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int baddr(input int b, input int i);
    return b * 256 + i;
  endfunction

  function automatic int src_idx(input int n, input int d);
    int x, y, sx, sy;
    x  = n % GW;
    y  = n / GW;
    sx = (x - CXT[d] + GW) % GW;
    sy = (y - CYT[d] + GH) % GH;
    return sy * GW + sx;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cur_bank", bus.cur_bank, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_wr_addr_data", {bus.wr_addr, bus.wr_data}, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    ref_bank = 0;
    exp_q.delete();
  endtask

  task automatic clear_mem();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int d = 0; d < 9; d++)
      for (int a = 0; a < 512; a++) ref_mem[d][a] = '0;
  endtask

  task automatic set_word(input int d, input int b, input int i, input logic [DW-1:0] v);
    ld_d   = 4'(d);
    ld_a   = AW'(baddr(b, i));
    ld_v   = v;
    ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
    ref_mem[d][baddr(b, i)] = v;
  endtask

  task automatic preload(input int pattern);
    case (pattern)
      0: set_word(3, 0, 5, 16'h00AA);
      1: begin
        set_word(2, 0, 15, 16'h1234);
        set_word(6, 0, 0, 16'h5678);
      end
      default: begin
        for (int d = 0; d < 9; d++)
          for (int n = 0; n < N; n++) set_word(d, 0, n, 16'($urandom_range(0, 65535)));
      end
    endcase
  endtask

  // One expected write word per destination cell, in sweep order.
  task automatic push_expected();
    logic [MW-1:0] w;
    int src, dst;
    src = ref_bank;
    dst = 1 - ref_bank;
    for (int n = 0; n < N; n++) begin
      w = '0;
      for (int d = 0; d < 9; d++) begin
        w[d*DW +: DW]           = ref_mem[d][baddr(src, src_idx(n, d))];
        w[9*DW + d*AW +: AW]    = AW'(baddr(dst, n));
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic ref_advance();
    int src, dst;
    src = ref_bank;
    dst = 1 - ref_bank;
    for (int d = 0; d < 9; d++)
      for (int n = 0; n < N; n++)
        ref_mem[d][baddr(dst, n)] = ref_mem[d][baddr(src, src_idx(n, d))];
    ref_bank = dst;
  endtask

  task automatic check_bank();
    int bad_n;
    bit found;
    for (int d = 0; d < 9; d++) begin
      bad_n = 0;
      found = 1'b0;
      for (int n = 0; n < N; n++)
        if (!found && mem[d][baddr(ref_bank, n)] !== ref_mem[d][baddr(ref_bank, n)]) begin
          bad_n = n;
          found = 1'b1;
        end
      check($sformatf("bank%0d_dir%0d_idx%0d", ref_bank, d, bad_n),
            mem[d][baddr(ref_bank, bad_n)], ref_mem[d][baddr(ref_bank, bad_n)]);
    end
  endtask

  // Starts a sweep and follows it cycle by cycle. rel counts cycles after the
  // start edge (rel=1 is the first SWEEP cycle).
  task automatic run_sweep(input int st_s, input int st_l, input int xs_rel, input int rst_rel,
                           output int done_rel, output int wr_cnt, output int stall_wr);
    logic [MW-1:0] e;
    int busy_bad;
    busy_bad = 0;
    done_rel = 0;
    wr_cnt   = 0;
    stall_wr = 0;
    bus.en    = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int rel = 1; rel <= 60; rel++) begin
      bus.en    = (rel >= st_s && rel < st_s + st_l) ? 1'b0 : 1'b1;
      bus.start = (rel == xs_rel);
      rst       = (rel == rst_rel);
      #1;
      if (rst_rel != 0 && rel == rst_rel + 1) begin
        check("midrst_busy", bus.busy, 0);
        check("midrst_wr_en", bus.wr_en, 0);
        check("midrst_cur_bank", bus.cur_bank, 0);
        break;
      end
      if (bus.wr_en != 9'd0) begin
        wr_cnt++;
        if (rel >= st_s && rel < st_s + st_l) stall_wr++;
        check("wr_en_all", bus.wr_en, 9'h1ff);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: write at rel %0d with empty expected queue", rel);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("wr_cell%0d", wr_cnt - 1), {bus.wr_addr, bus.wr_data}, e);
        end
      end
      if (bus.done) begin
        done_rel = rel;
        break;
      end
      if (bus.busy !== 1'b1) busy_bad++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.en    = 1'b1;
    rst       = 1'b0;
    if (rst_rel == 0) check("busy_during_sweep", busy_bad, 0);
  endtask

  task automatic finish_sweep(input int done_rel, input int wr_cnt, input int stall_wr,
                              input int exp_done, input int exp_stall_wr);
    check("done_cycle", done_rel, exp_done);
    check("wr_count", wr_cnt, N);
    check("stall_wr_count", stall_wr, exp_stall_wr);
    check("exp_q_empty", exp_q.size(), 0);
    ref_advance();
    @(negedge clk);
    #1;
    check("done_pulse_one_cycle", bus.done, 0);
    check("idle_after_done", bus.busy, 0);
    check("cur_bank_after", bus.cur_bank, ref_bank);
    check_bank();
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int pattern;
    int st_s;
    int st_l;
    int exp_done;
    int exp_stall_wr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int dr, wc, sw;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.start = 1'b0;
    ref_bank = 0;

    vecs[0] = '{pattern: 0, st_s: 0, st_l: 0, exp_done: 18, exp_stall_wr: 0};
    vecs[1] = '{pattern: 1, st_s: 0, st_l: 0, exp_done: 18, exp_stall_wr: 0};
    vecs[2] = '{pattern: 0, st_s: 8, st_l: 5, exp_done: 23, exp_stall_wr: 1};
    vecs[3] = '{pattern: 2, st_s: 0, st_l: 0, exp_done: 18, exp_stall_wr: 0};

    for (int i = 0; i < 4; i++) begin
      do_reset();
      clear_mem();
      preload(vecs[i].pattern);
      push_expected();
      run_sweep(vecs[i].st_s, vecs[i].st_l, 0, 0, dr, wc, sw);
      finish_sweep(dr, wc, sw, vecs[i].exp_done, vecs[i].exp_stall_wr);
      if (vecs[i].pattern == 0) begin
        check("e_dest_idx6", mem[3][baddr(1, 6)], 16'h00AA);
        check("e_dest_idx5", mem[3][baddr(1, 5)], 16'h0000);
      end
      if (vecs[i].pattern == 1) begin
        check("ne_wrap_idx0", mem[2][baddr(1, 0)], 16'h1234);
        check("sw_wrap_idx15", mem[6][baddr(1, 15)], 16'h5678);
      end
    end

    // Back-to-back sweeps, with a stray start while busy
    do_reset();
    clear_mem();
    preload(0);
    push_expected();
    run_sweep(0, 0, 0, 0, dr, wc, sw);
    finish_sweep(dr, wc, sw, 18, 0);
    push_expected();
    run_sweep(0, 0, 5, 0, dr, wc, sw);
    finish_sweep(dr, wc, sw, 18, 0);
    check("second_e_idx7_bank0", mem[3][baddr(0, 7)], 16'h00AA);
    repeat (3) @(negedge clk);
    #1;
    check("no_restart_from_stray_start", bus.busy, 0);

    // Reset in the middle of a sweep, then a clean sweep
    do_reset();
    clear_mem();
    preload(0);
    push_expected();
    run_sweep(0, 0, 0, 8, dr, wc, sw);
    exp_q.delete();
    ref_bank = 0;
    @(negedge clk);
    push_expected();
    run_sweep(0, 0, 0, 0, dr, wc, sw);
    finish_sweep(dr, wc, sw, 18, 0);
    check("post_rst_e_idx6", mem[3][baddr(1, 6)], 16'h00AA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
